interval_timer_sched: RTL
=========================

// Module: interval_timer_sched
// PURPOSE
//   Shares one 9-bit up-counter among N_REQ requesters that each need a timed interval.
//   Each requester is served in turn, round-robin; only one interval runs at a time.
//   A requester raises req with its interval length on dly; the scheduler grants it,
//   counts 0..dly, then pulses done. Sits between control FSMs and the shared count resource.
// PARAMETERS
//   N_REQ  4  number of requesters (2..8)
//   CNT_W  9  counter/interval width; max interval value 2**CNT_W-1
// PORTS
//   clk    in   1            clock, rising edge
//   reset  in   1            reset, synchronous, active-high
//   req    in   N_REQ        per-requester request level; held until done or withdrawn
//   dly    in   N_REQ*CNT_W  per-requester interval; slice i = dly[i*CNT_W +: CNT_W]
//   grant  out  N_REQ        one-hot owner of counter; all-zero when idle
//   done   out  N_REQ        one-cycle completion pulse to the owner
//   busy   out  1            1 while in RUN or DONE
//   count  out  CNT_W        current count value of the active interval
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, grant=0, done=0, busy=0, count=0,
//     rr pointer=0, so requester 0 has highest priority first. Reset wins over all inputs.
//   - FSM states IDLE, RUN, DONE.
//   - IDLE: if any req is set at edge t, pick the first set bit scanning from ptr upward
//     (mod N_REQ). At t+1: state=RUN, grant=onehot(i), count=0, busy=1.
//     Latch tgt=dly slice i. ptr=(i+1) mod N_REQ. If no req, stay IDLE.
//   - RUN, count!=tgt: count<=count+1. dly changes during RUN are ignored (tgt latched).
//   - RUN, count==tgt: next state DONE, done[i]=1 one cycle, grant held, count held.
//     RUN therefore lasts tgt+1 cycles. grant is high tgt+2 cycles including DONE.
//   - DONE: next state IDLE, grant=0, done=0, busy=0, count=0.
//     After DONE there is one IDLE cycle before the next grant.
//   - Withdrawal: req[i] low for the owner in RUN with count!=tgt ->
//     next cycle IDLE, grant=0, count=0, no done pulse.
//   - Simultaneous withdrawal and count==tgt: completion wins, done pulses.
//   - dly=0: one RUN cycle (count=0), then DONE.
//   - dly=2**CNT_W-1: count reaches max with no wrap.
//     count never exceeds tgt, so it never wraps.
//   - Owner keeping req high after done is a new request. ptr has already moved past it,
//     so it is served after the other pending requesters.
//   - Requests arriving during RUN/DONE wait. Arbitration happens only in IDLE.
//   - grant is always one-hot or zero. done is asserted only together with the matching grant bit.
// TESTING
//   1 Single: req0=1, dly0=5 from reset -> grant=0001 for 7 cycles,
//     count 0..5 then held at 5, done0 on the 7th grant cycle.
//   2 Contention: req0=req1=1, dly=3 each -> req0 served first, then 1 IDLE cycle,
//     then grant=0010. Two done pulses, 6 cycles apart from grant to grant.
//   3 Round-robin: all 4 req held high, dly=1 -> grant sequence 0001,0010,0100,1000,0001.
//     No starvation.
//   4 Zero interval: req2=1, dly2=0 -> grant 2 cycles, count=0, done2 on the 2nd cycle.
//   5 Withdraw: req1, dly1=10; drop req1 when count=4 -> grant=0 next cycle, no done1.
//     A pending req3 is then granted.
//   6 Reset mid-run: assert reset when count=7 -> next cycle all outputs 0.
//     After reset, ptr=0, so req0 wins over req2.
//   7 Max: dly=511 -> count reaches 511 without wrap, done after 512 RUN cycles.

Source files
------------

// File: rtl/interval_timer_sched_if.sv
// Bundle of request/interval inputs and grant/completion outputs for the shared interval timer.
// The requesters drive through master; the scheduler uses slave.
interface interval_timer_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 9
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] dly;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [CNT_W-1:0]       count;

    modport master (
        output req, dly,
        input  grant, done, busy, count
    );

    modport slave (
        input  req, dly,
        output grant, done, busy, count
    );
endinterface

// File: rtl/interval_timer_sched.sv
// Round-robin scheduler sharing one up-counter among N_REQ interval requesters.
// A granted owner counts 0..dly, then receives a one-cycle done pulse.
module interval_timer_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    interval_timer_sched_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [N_REQ-1:0] done_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] tgt_reg;
    logic [PTR_W-1:0] ptr_reg;

    logic [CNT_W-1:0] dly_arr [N_REQ];
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [N_REQ-1:0] pick_onehot;
    logic             owner_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_dly
            assign dly_arr[gi] = bus.dly[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Scan from ptr upward; iterating from the far end lets the nearest set bit win.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_reg) + k) % N_REQ;
            if (bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign ptr_next    = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign owner_req   = |(bus.req & grant_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            grant_reg <= '0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            tgt_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= '0;
                    if (pick_valid) begin
                        state_reg <= S_RUN;
                        grant_reg <= pick_onehot;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        tgt_reg   <= dly_arr[pick_idx];
                        ptr_reg   <= ptr_next;
                    end
                end
                S_RUN: begin
                    // Completion takes precedence over a same-cycle withdrawal.
                    if (count_reg == tgt_reg) begin
                        state_reg <= S_DONE;
                        done_reg  <= grant_reg;
                    end else if (!owner_req) begin
                        state_reg <= S_IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    grant_reg <= '0;
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    count_reg <= '0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    grant_reg <= '0;
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_reg;
    assign bus.done  = done_reg;
    assign bus.busy  = busy_reg;
    assign bus.count = count_reg;
endmodule
